sa_autosa_bdma_rd_cdt_ctrl: RTL and testbench

Credit-based read-request controller between the BDMA load engine and the two read-request ports (MCIF, CVIF). It routes each load read request to the port chosen by its RAM type. It admits a request only when that port's read-return latency FIFO has room for the full response, using the `*_rd_cdt_lat_fifo_pop` credits issued by the store side. It also reports credit stalls to the CSB performance counters and reports idle to clock gating.

---
 rtl/sa_autosa_bdma_rd_cdt_ctrl.sv | 78 +++++++
 tb/tb_sa_autosa_bdma_rd_cdt_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sa_autosa_bdma_rd_cdt_ctrl.sv
// sa_autosa_bdma_rd_cdt_ctrl: routes BDMA load read requests to MCIF/CVIF, gated by
// per-port latency-FIFO credits, with stall/idle/error reporting.
module sa_autosa_bdma_rd_cdt_ctrl #(
  parameter int LAT_DEPTH = 256,
  parameter int CW = $clog2(LAT_DEPTH + 1)
) (
  input  logic        autosa_core_clk,
  input  logic        autosa_core_rstn,
  input  logic        ld_rd_req_valid,
  output logic        ld_rd_req_ready,
  input  logic [78:0] ld_rd_req_pd,
  input  logic        ld_rd_req_ram_type,
  output logic        bdma2mcif_rd_req_valid,
  input  logic        bdma2mcif_rd_req_ready,
  output logic [78:0] bdma2mcif_rd_req_pd,
  output logic        bdma2cvif_rd_req_valid,
  input  logic        bdma2cvif_rd_req_ready,
  output logic [78:0] bdma2cvif_rd_req_pd,
  input  logic        bdma2mcif_rd_cdt_lat_fifo_pop,
  input  logic        bdma2cvif_rd_cdt_lat_fifo_pop,
  output logic        rd_cdt_stall_inc,
  output logic        rd_cdt_idle,
  output logic        rd_cdt_err
);
  localparam logic [15:0] DEPTH16 = 16'(LAT_DEPTH);
  localparam logic [CW-1:0] DEPTH = CW'(LAT_DEPTH);
  logic [CW-1:0] avail_m, avail_c, avail_m_n, avail_c_n, debit, deb_m, deb_c;
  logic [15:0] need, dest_avail;
  logic [78:0] stage_pd;
  logic stage_vld, stage_dest, stage_vld_n;
  logic oversize, credit_ok, stage_free, accept, ovf_m, ovf_c;

  assign need = {1'b0, ld_rd_req_pd[78:64]} + 16'd1;
  assign dest_avail = 16'(ld_rd_req_ram_type ? avail_c : avail_m);
  assign oversize = need > DEPTH16;
  // An oversize request drains the whole FIFO, so it waits for a completely full counter.
  assign credit_ok = (need <= dest_avail) || (oversize && dest_avail == DEPTH16);
  assign stage_free = !stage_vld || (stage_dest ? bdma2cvif_rd_req_ready : bdma2mcif_rd_req_ready);
  assign ld_rd_req_ready = stage_free && credit_ok;
  assign accept = ld_rd_req_valid && ld_rd_req_ready;
  assign debit = oversize ? DEPTH : need[CW-1:0];
  assign deb_m = (accept && !ld_rd_req_ram_type) ? debit : '0;
  assign deb_c = (accept && ld_rd_req_ram_type) ? debit : '0;
  assign ovf_m = bdma2mcif_rd_cdt_lat_fifo_pop && avail_m == DEPTH && deb_m == '0;
  assign ovf_c = bdma2cvif_rd_cdt_lat_fifo_pop && avail_c == DEPTH && deb_c == '0;
  assign avail_m_n = ovf_m ? DEPTH : avail_m - deb_m + CW'(bdma2mcif_rd_cdt_lat_fifo_pop);
  assign avail_c_n = ovf_c ? DEPTH : avail_c - deb_c + CW'(bdma2cvif_rd_cdt_lat_fifo_pop);
  assign stage_vld_n = accept || !stage_free;

  assign bdma2mcif_rd_req_valid = stage_vld && !stage_dest;
  assign bdma2cvif_rd_req_valid = stage_vld && stage_dest;
  assign bdma2mcif_rd_req_pd = stage_pd;
  assign bdma2cvif_rd_req_pd = stage_pd;

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      avail_m <= DEPTH;
      avail_c <= DEPTH;
      stage_vld <= 1'b0;
      stage_dest <= 1'b0;
      stage_pd <= '0;
      rd_cdt_stall_inc <= 1'b0;
      rd_cdt_idle <= 1'b1;
      rd_cdt_err <= 1'b0;
    end else begin
      avail_m <= avail_m_n;
      avail_c <= avail_c_n;
      stage_vld <= stage_vld_n;
      if (accept) begin
        stage_dest <= ld_rd_req_ram_type;
        stage_pd <= ld_rd_req_pd;
      end
      rd_cdt_stall_inc <= ld_rd_req_valid && stage_free && !credit_ok;
      rd_cdt_idle <= !stage_vld_n && avail_m_n == DEPTH && avail_c_n == DEPTH;
      rd_cdt_err <= rd_cdt_err || (accept && oversize) || ovf_m || ovf_c;
    end
  end
endmodule

// File: tb/tb_sa_autosa_bdma_rd_cdt_ctrl.sv
// tb_sa_autosa_bdma_rd_cdt_ctrl: directed and random checks against a credit/queue model.
module tb_sa_autosa_bdma_rd_cdt_ctrl;
  localparam int DEPTH = 256;
  logic clk = 0, rstn = 0;
  logic ld_valid = 0, ld_ready, ld_rt = 0;
  logic [78:0] ld_pd = '0;
  logic m_valid, m_ready = 1, c_valid, c_ready = 1, m_pop = 0, c_pop = 0;
  logic [78:0] m_pd, c_pd;
  logic stall, idle, err;
  int avail[2];
  bit sv, sd, stall_q, idle_q, err_q, acc_q;
  logic [78:0] spd;
  int total = 0, fails = 0, req_id = 0;

  sa_autosa_bdma_rd_cdt_ctrl dut (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn),
    .ld_rd_req_valid(ld_valid), .ld_rd_req_ready(ld_ready), .ld_rd_req_pd(ld_pd),
    .ld_rd_req_ram_type(ld_rt),
    .bdma2mcif_rd_req_valid(m_valid), .bdma2mcif_rd_req_ready(m_ready), .bdma2mcif_rd_req_pd(m_pd),
    .bdma2cvif_rd_req_valid(c_valid), .bdma2cvif_rd_req_ready(c_ready), .bdma2cvif_rd_req_pd(c_pd),
    .bdma2mcif_rd_cdt_lat_fifo_pop(m_pop), .bdma2cvif_rd_cdt_lat_fifo_pop(c_pop),
    .rd_cdt_stall_inc(stall), .rd_cdt_idle(idle), .rd_cdt_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [78:0] got, input logic [78:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 0; ld_valid = 0; m_pop = 0; c_pop = 0; m_ready = 1; c_ready = 1;
    @(posedge clk); #1;
    avail = '{DEPTH, DEPTH}; sv = 0; sd = 0; spd = '0; stall_q = 0; idle_q = 1; err_q = 0;
    chk("rst_m_valid", m_valid, 0); chk("rst_c_valid", c_valid, 0);
    chk("rst_m_pd", m_pd, 0); chk("rst_c_pd", c_pd, 0);
    chk("rst_stall", stall, 0); chk("rst_err", err, 0); chk("rst_idle", idle, 1);
    rstn = 1;
  endtask

  // One clock: check every output against the model mid-cycle, then advance the model.
  task automatic cyc();
    int need, deb, pop;
    bit ok, free, er, prdy;
    #4;
    need = int'(ld_pd[78:64]) + 1;
    ok = need <= avail[ld_rt] || (need > DEPTH && avail[ld_rt] == DEPTH);
    prdy = sd ? c_ready : m_ready;
    free = !sv || prdy;
    er = free && ok;
    chk("ready", ld_ready, er);
    chk("m_valid", m_valid, sv && !sd); chk("c_valid", c_valid, sv && sd);
    chk("m_pd", m_pd, spd); chk("c_pd", c_pd, spd);
    chk("stall", stall, stall_q); chk("idle", idle, idle_q); chk("err", err, err_q);
    acc_q = ld_valid && er;
    for (int p = 0; p < 2; p++) begin
      deb = (acc_q && int'(ld_rt) == p) ? (need > DEPTH ? DEPTH : need) : 0;
      pop = p == 0 ? int'(m_pop) : int'(c_pop);
      if (pop == 1 && avail[p] == DEPTH && deb == 0) err_q = 1;
      else avail[p] += pop - deb;
    end
    if (acc_q && need > DEPTH) err_q = 1;
    stall_q = ld_valid && free && !ok;
    if (acc_q) begin sv = 1; sd = ld_rt; spd = ld_pd; req_id++; end
    else if (sv && prdy) sv = 0;
    idle_q = !sv && avail[0] == DEPTH && avail[1] == DEPTH;
    @(posedge clk); #1;
  endtask

  task automatic drv(input bit v, input bit rt, input int size, input bit rm, input bit rc,
                     input bit pm, input bit pc);
    ld_valid = v; ld_rt = rt; ld_pd = {15'(size), 64'(req_id * 32)};
    m_ready = rm; c_ready = rc; m_pop = pm; c_pop = pc;
    cyc();
  endtask

  task automatic ret(input int nm, input int nc);
    for (int i = 0; i < (nm > nc ? nm : nc); i++) drv(0, 0, 0, 1, 1, i < nm, i < nc);
  endtask

  initial begin
    bit pend;
    bit prt;
    int psz;
    do_reset();
    // single MCIF request then credit return
    drv(1, 0, 3, 1, 1, 0, 0);
    chk("t1_avail_m", dut.avail_m, 252); chk("t1_m_valid", m_valid, 1); chk("t1_c_valid", c_valid, 0);
    ret(4, 0);
    chk("t1_avail_back", dut.avail_m, 256); chk("t1_idle", idle, 1);
    // exhaust MCIF credits, stall, then refill
    for (int i = 0; i < 4; i++) drv(1, 0, 63, 1, 1, 0, 0);
    chk("t2_avail_zero", dut.avail_m, 0);
    for (int i = 0; i < 3; i++) drv(1, 0, 63, 1, 1, 0, 0);
    chk("t2_stall", stall, 1);
    for (int i = 0; i < 64; i++) drv(1, 0, 63, 1, 1, 1, 0);
    chk("t2_avail_64", dut.avail_m, 64);
    drv(1, 0, 63, 1, 1, 0, 0);
    chk("t2_accepted", acc_q, 1);
    ret(256, 0);
    // alternating destinations, no bubble
    for (int i = 0; i < 8; i++) drv(1, 1'(i), 0, 1, 1, 0, 0);
    chk("t3_avail_m", dut.avail_m, 252); chk("t3_avail_c", dut.avail_c, 252);
    ret(4, 4);
    // CVIF backpressure
    drv(1, 1, 5, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, 0, 2, 1, 0, 0, 0);
    chk("t4_c_held", c_valid, 1);
    drv(1, 0, 2, 1, 1, 0, 0);
    chk("t4_m_valid", m_valid, 1);
    ret(3, 6);
    // simultaneous debit and pop
    drv(1, 0, 245, 1, 1, 0, 0);
    chk("t5_avail_10", dut.avail_m, 10);
    drv(1, 0, 1, 1, 1, 1, 0);
    chk("t5_avail_9", dut.avail_m, 9);
    ret(247, 0);
    // oversize request waits for full counter
    drv(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) drv(1, 0, 300, 1, 1, 0, 0);
    drv(1, 0, 300, 1, 1, 1, 0);
    drv(1, 0, 300, 1, 1, 0, 0);
    chk("t6_avail_0", dut.avail_m, 0); chk("t6_err", err, 1);
    do_reset();
    // pop at a full counter
    drv(0, 0, 0, 1, 1, 1, 0);
    chk("t7_avail_sat", dut.avail_m, 256); chk("t7_err", err, 1);
    do_reset();
    // random traffic with legal credit returns
    pend = 0; prt = 0; psz = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1; prt = 1'($urandom);
        psz = $urandom_range(0, 19) == 0 ? $urandom_range(256, 400) : $urandom_range(0, 40);
      end
      drv(pend, prt, pend ? psz : 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          avail[0] < DEPTH && $urandom_range(0, 1) == 1, avail[1] < DEPTH && $urandom_range(0, 1) == 1);
      if (acc_q) pend = 0;
    end
    ret(DEPTH - avail[0], DEPTH - avail[1]);
    drv(0, 0, 0, 1, 1, 0, 0);
    chk("rand_idle", idle, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
